// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   In-order fetch buffer between the fetch (F) and decode (D) stages. It
//   holds up to DEPTH {instruction, PC, PC+4} entries. The decode stage is
//   always driven with the head entry, and fetch sees back-pressure on FullF.
//   StallD holds the head in place. FlushD discards every buffered entry and
//   the entry presented in the same cycle.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   InstrF    fetched instruction        PCF / PCPlus4F  its PC and PC+4
//   ValidF    fetch presents an entry this cycle
//   StallD    decode holds the current head
//   FlushD    discard all buffered and incoming entries
//   InstrD    head instruction           PCD / PCPlus4D  head PC and PC+4
//   ValidD    head entry is valid (buffer not empty)
//   FullF     buffer full; fetch must not present new entries
//   DropF     registered pulse: an entry was refused because the buffer was full
//   Count     current occupancy
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 5,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] InstrF,
  input  logic [PC_W-1:0]    PCF,
  input  logic [PC_W-1:0]    PCPlus4F,
  input  logic               ValidF,
  input  logic               StallD,
  input  logic               FlushD,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD,
  output logic               FullF,
  output logic               DropF,
  output logic [CNT_W-1:0]   Count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PC_W-1:0]    pc4_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             drop_reg;

  logic push;
  logic pop;
  logic full;
  logic not_empty;

  // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign not_empty = (count_reg != '0);

  // A full buffer refuses the incoming entry even when the head pops in the
  // same cycle, so FullF depends only on the occupancy and not on StallD.
  assign push = ValidF && !FlushD && !full;
  assign pop  = not_empty && !StallD && !FlushD;

  // Storage: only the entry at the write pointer is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        pc4_mem[i]   <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_reg] <= InstrF;
      pc_mem[wr_ptr_reg]    <= PCF;
      pc4_mem[wr_ptr_reg]   <= PCPlus4F;
    end
  end

  // Pointers, occupancy and the drop pulse. A flush takes priority over
  // everything else except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else if (FlushD) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      drop_reg <= ValidF && full;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Head read is combinational. An empty buffer presents a zeroed bubble so
  // stale storage never leaks into decode.
  always_comb begin
    ValidD   = not_empty;
    InstrD   = '0;
    PCD      = '0;
    PCPlus4D = '0;
    if (not_empty) begin
      InstrD   = instr_mem[rd_ptr_reg];
      PCD      = pc_mem[rd_ptr_reg];
      PCPlus4D = pc4_mem[rd_ptr_reg];
    end
  end

  assign FullF = full;
  assign DropF = drop_reg;
  assign Count = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
//   Drives a DEPTH=4 and a DEPTH=3 instance of if_id_queue with the same
//   stimulus. Each instance is compared against its own queue-based
//   reference model after every clock edge.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  pc;
    logic [4:0]  pc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrF = '0;
  logic [4:0]  PCF = '0;
  logic [4:0]  PCPlus4F = '0;
  logic        ValidF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;

  logic [31:0] instr_a, instr_b;
  logic [4:0]  pc_a, pc_b, pc4_a, pc4_b;
  logic        valid_a, valid_b, full_a, full_b, drop_a, drop_b;
  logic [2:0]  count_a;
  logic [1:0]  count_b;

  int passed = 0;
  int total  = 0;

  ent_t q4[$];
  ent_t q3[$];
  bit   drop4 = 0;
  bit   drop3 = 0;

  always #5 clk = ~clk;

  if_id_queue #(.INSTR_W(32), .PC_W(5), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF), .StallD(StallD), .FlushD(FlushD),
    .InstrD(instr_a), .PCD(pc_a), .PCPlus4D(pc4_a), .ValidD(valid_a),
    .FullF(full_a), .DropF(drop_a), .Count(count_a)
  );

  if_id_queue #(.INSTR_W(32), .PC_W(5), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF), .StallD(StallD), .FlushD(FlushD),
    .InstrD(instr_b), .PCD(pc_b), .PCPlus4D(pc4_b), .ValidD(valid_b),
    .FullF(full_b), .DropF(drop_b), .Count(count_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model of one clock edge: a flush empties the buffer; otherwise
  // a non-empty head leaves unless stalled, and a new entry joins only if there
  // was room before the edge.
  task automatic model_edge(input int d, input bit vf, input bit st, input bit fl,
                            input ent_t e, inout ent_t q[$], inout bit drop);
    int n;
    n = q.size();
    if (fl) begin
      q.delete();
      drop = 0;
    end else begin
      drop = vf && (n == d);
      if (n > 0 && !st) void'(q.pop_front());
      if (vf && n < d) q.push_back(e);
    end
  endtask

  task automatic check_one(input string n, input int d, input ent_t q[$], input bit drop,
                           input logic vd, input logic [31:0] ins, input logic [4:0] pc,
                           input logic [4:0] pc4, input logic fu, input logic dr,
                           input logic [2:0] cnt);
    ent_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    chk({n, ".ValidD"},   64'(vd),  64'(q.size() > 0));
    chk({n, ".InstrD"},   64'(ins), 64'(h.instr));
    chk({n, ".PCD"},      64'(pc),  64'(h.pc));
    chk({n, ".PCPlus4D"}, 64'(pc4), 64'(h.pc4));
    chk({n, ".FullF"},    64'(fu),  64'(q.size() == d));
    chk({n, ".DropF"},    64'(dr),  64'(drop));
    chk({n, ".Count"},    64'(cnt), 64'(q.size()));
  endtask

  task automatic check_all(input string step_name);
    check_one({step_name, "/d4"}, 4, q4, drop4, valid_a, instr_a, pc_a, pc4_a,
              full_a, drop_a, count_a);
    check_one({step_name, "/d3"}, 3, q3, drop3, valid_b, instr_b, pc_b, pc4_b,
              full_b, drop_b, {1'b0, count_b});
  endtask

  // One clock cycle: drive inputs, take the edge, update models, compare.
  task automatic step(input string name, input bit vf, input logic [31:0] ins,
                      input logic [4:0] pc, input logic [4:0] pc4,
                      input bit st, input bit fl);
    ent_t e;
    ValidF = vf; InstrF = ins; PCF = pc; PCPlus4F = pc4; StallD = st; FlushD = fl;
    e.instr = ins; e.pc = pc; e.pc4 = pc4;
    @(posedge clk);
    model_edge(4, vf, st, fl, e, q4, drop4);
    model_edge(3, vf, st, fl, e, q3, drop3);
    #1;
    check_all(name);
    $display("step %-10s vf=%0b st=%0b fl=%0b instr=%08h | d4 cnt=%0d vd=%0b drop=%0b | d3 cnt=%0d vd=%0b drop=%0b",
             name, vf, st, fl, ins, count_a, valid_a, drop_a, count_b, valid_b, drop_b);
  endtask

  // Reset asserted asynchronously mid-cycle, released just after a rising edge.
  task automatic async_reset(input string name);
    ValidF = 0; StallD = 0; FlushD = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q4.delete(); q3.delete(); drop4 = 0; drop3 = 0;
    #1;
    check_all({name, "-fall"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all({name, "-rel"});
    $display("reset %s: d4 cnt=%0d vd=%0b | d3 cnt=%0d vd=%0b", name, count_a, valid_a,
             count_b, valid_b);
  endtask

  initial begin
    logic [31:0] r;
    // Power-on reset.
    #1;
    check_all("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("por-rel");

    // Idle, then an asynchronous reset pulse mid-cycle.
    step("idle", 0, 32'h0, 5'd0, 5'd0, 0, 0);
    async_reset("rst1");

    // Single push, visible one cycle later, popped the next edge.
    step("push1", 1, 32'h00A00093, 5'd4, 5'd8, 0, 0);
    step("pop1", 0, 32'h0, 5'd0, 5'd0, 0, 0);

    // Stalled fill: five pushes, the extra ones are refused.
    for (int i = 0; i < 5; i++)
      step("fill", 1, 32'h1000_0000 + 32'(i), 5'(i), 5'(i + 4), 1, 0);
    // Stall held on a full buffer with no new entry.
    step("hold", 0, 32'h0, 5'd0, 5'd0, 1, 0);
    // Release stall and drain.
    for (int i = 0; i < 5; i++)
      step("drain", 0, 32'h0, 5'd0, 5'd0, 0, 0);

    // Full buffer, pop and push in the same cycle: push refused.
    for (int i = 0; i < 4; i++)
      step("refill", 1, 32'h2000_0000 + 32'(i), 5'(i + 8), 5'(i + 12), 1, 0);
    step("full-pop", 1, 32'h2BAD_0000, 5'd31, 5'd3, 0, 0);

    // Flush with an incoming entry, then a normal push.
    step("flush", 1, 32'h3BAD_0000, 5'd30, 5'd2, 0, 1);
    step("post-fl", 1, 32'h4000_0001, 5'd16, 5'd20, 0, 0);
    step("post-fl2", 0, 32'h0, 5'd0, 5'd0, 0, 0);

    // Continuous stream across pointer wrap-around.
    for (int i = 0; i < 10; i++)
      step("stream", 1, 32'h5000_0000 + 32'(i), 5'(i), 5'(i + 4), 0, 0);
    for (int i = 0; i < 4; i++)
      step("stream-dr", 0, 32'h0, 5'd0, 5'd0, 0, 0);

    // Randomised traffic, with one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if (i == 150) async_reset("rst2");
      step("rand", ($urandom_range(0, 9) < 7), r, 5'($urandom), 5'($urandom),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry in-order fetch buffer between the fetch and decode stages.
- Decouples fetch from decode stalls, carries an explicit valid bit per entry, and keeps the FlushD/StallD semantics of the existing stage register.
- Drives decode with the head entry and signals back-pressure to fetch through FullF.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 5, width of PC and PC+4 fields
DEPTH, 4, number of buffered entries (integer >= 2, need not be a power of two)
CNT_W, $clog2(DEPTH+1), occupancy counter width (localparam, derived)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
InstrF  input  INSTR_W  fetched instruction
PCF  input  PC_W  PC of fetched instruction
PCPlus4F  input  PC_W  PC+4 of fetched instruction
ValidF  input  1  fetch presents a valid entry this cycle
StallD  input  1  decode holds the current head
FlushD  input  1  discard all buffered and incoming entries
InstrD  output  INSTR_W  head instruction to decode
PCD  output  PC_W  head PC
PCPlus4D  output  PC_W  head PC+4
ValidD  output  1  head entry is valid
FullF  output  1  count == DEPTH; fetch must not present new entries
DropF  output  1  one-cycle pulse: a ValidF entry was refused because the buffer was full
Count  output  CNT_W  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): read pointer, write pointer and count go to 0; DropF=0; all storage entries clear to 0.
- Reset values follow from an empty buffer: ValidD=0, InstrD/PCD/PCPlus4D=0, FullF=0, Count=0.
- Reset deasserts synchronously to clk from the bench's point of view. A reset taken mid-operation discards all entries without exception.
- Storage: DEPTH flop entries {Instr, PC, PCPlus4}. Pointers wrap from DEPTH-1 to 0; there is no power-of-two assumption.
- Outputs are combinational reads of the head entry, with no added latency.
- When Count==0, ValidD=0 and InstrD/PCD/PCPlus4D are driven to 0, i.e. the decode stage sees a bubble.
- Push (sampled at the rising edge): push = ValidF && !FlushD && (Count < DEPTH). The entry is written at the write pointer and the write pointer advances.
- Pop (sampled at the rising edge): pop = ValidD && !StallD && !FlushD. The read pointer advances.
- Latency: an entry pushed at edge N into an empty buffer appears on the D outputs after edge N; it is popped at edge N+1 if StallD is low.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full and pop in the same cycle: no push is accepted. FullF depends only on Count, with no combinational path from StallD.
- DropF: registered. DropF=1 in the cycle after an edge where ValidF && !FlushD && Count==DEPTH; otherwise 0.
- FlushD (synchronous, highest priority after reset): at the edge, pointers and count go to 0. ValidF is ignored that cycle (entry dropped, DropF stays 0) and StallD is ignored.
- After a flush: ValidD=0 and the D outputs read 0 from the next cycle onward.
- StallD with Count==0: no effect; pushes are still accepted.
- StallD with a full buffer: state holds and each ValidF produces DropF.
- Order is strictly FIFO; entries are never reordered or duplicated.

Test Plan:
- Reset then idle, with rst_n pulsed low asynchronously mid-cycle -> ValidD=0, Count=0, FullF=0, InstrD=0 immediately after the rst_n fall.
- Push 0x00A00093/PC=4/PC+4=8 with StallD=0 -> D outputs show that entry one cycle later with ValidD=1; it is popped the next edge and Count returns to 0.
- StallD=1, push 5 entries with DEPTH=4 -> Count=4, FullF=1, DropF=1 for the 5th; release StallD -> the 4 entries emerge in order; the 5th is never seen.
- Full buffer, StallD=0 and ValidF=1 in the same cycle -> head popped, new entry refused (DropF=1), Count=3.
- Count=3, FlushD=1 with ValidF=1 -> next cycle Count=0, ValidD=0, InstrD=0, DropF=0; the following push is seen normally.
- DEPTH=3 build: 10 push/pop cycles across wrap-around -> output sequence equals input sequence; Count never exceeds 3.
